fifo_axis_reader: RTL and testbench
===================================

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, the FIFO word width; bit DATA_WIDTH-1 is tlast and bits DATA_WIDTH-2:0 are payload.
REQ-002 SHALL have port clk  input  1  sole clock, the FIFO read-side clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag (pessimistic).
REQ-006 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-007 SHALL have port m_axis_tdata  output  DATA_WIDTH-1  stream payload.
REQ-008 SHALL have port m_axis_tlast  output  1  end of frame.
REQ-009 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-010 SHALL have port m_axis_tready  input  1  sink ready.
REQ-011 SHALL have port frame_active  output  1  high between first and last accepted beat of a frame.
REQ-012 SHALL have port underrun  output  1  1-cycle pulse, frame stalled on data starvation.

Function
REQ-013 SHALL hold a 2-entry output buffer: occupancy counter occ (0..2) plus an in-flight bit infl set the cycle after fifo_rd_en.
REQ-014 SHALL assert fifo_rd_en only when fifo_empty=0 and (occ + infl - pop) < 2, where pop = m_axis_tvalid & m_axis_tready in that cycle.
REQ-015 SHALL write fifo_rd_data into the buffer in the cycle infl=1; the FIFO's fixed 1-cycle read latency is never bypassed.
REQ-016 SHALL drive m_axis_tvalid = (occ > 0), with tdata/tlast taken from the head entry; head stays stable while tvalid=1 and tready=0.
REQ-017 SHALL support simultaneous push and pop in one cycle; occ stays unchanged in that case.
REQ-018 SHALL never overflow: push with occ=2 and no pop is unreachable; never pop with occ=0.
REQ-019 SHALL give a read-to-tvalid latency of 2 cycles, sustaining 1 beat/cycle while FIFO is non-empty and tready=1.
REQ-020 SHALL run the frame FSM IDLE and IN_FRAME, with frame_active = (state == IN_FRAME).
REQ-021 SHALL move IDLE->IN_FRAME on an accepted beat with tlast=0; a tlast=1 beat accepted in IDLE is a single-beat frame and the FSM stays IDLE.
REQ-022 SHALL move IN_FRAME->IDLE on an accepted beat with tlast=1.
REQ-023 SHALL pulse underrun for each cycle where state=IN_FRAME and m_axis_tvalid=0; there is no pulse in IDLE.

Reset
REQ-024 SHALL, with reset_n=0 at a clock edge, clear occ, infl, buffer pointers and FSM (IDLE).
REQ-025 SHALL hold fifo_rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_active=0 and underrun=0 during and after reset.
REQ-026 SHALL discard buffered and in-flight data when reset is asserted mid-frame; no beat is emitted after reset release until a new FIFO read completes.

Configuration
REQ-027 SHALL, with FIFO_AXIS_FRAME_CNT_EN defined, add output frame_cnt (16 bits), reset to 0 and incremented on each accepted tlast=1 beat, wrapping 0xFFFF->0x0000.
REQ-028 SHALL, without FIFO_AXIS_FRAME_CNT_EN, omit the frame_cnt port and counter; all other behaviour is identical.

Structure
REQ-029 SHALL place the frame FSM state typedef (IDLE, IN_FRAME) and the FRAME_CNT_WIDTH=16 constant in shared package eth_fifo_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module axis_skid_buf (push, pop, occ, head data); the FSM and read control stay in the top level.

Verification
REQ-031 SHALL cover reset with FIFO holding 3 words: tvalid=0 and rd_en=0 throughout reset; first tvalid exactly 2 cycles after the first rd_en following release.
REQ-032 SHALL cover streaming: FIFO preloaded with 0x0A1..0x0A4 (last word tlast=1) and tready=1 -> 4 consecutive beats, tlast on beat 4, frame_active high beats 1-3, underrun never set.
REQ-033 SHALL cover backpressure: tready=0 for 5 cycles mid-frame -> tdata stable, occ=2, rd_en=0 until tready rises, with no lost or duplicated beats.
REQ-034 SHALL cover underrun: FIFO empties after beat 2 of a 4-beat frame for 3 cycles -> underrun high 3 cycles, frame_active stays 1.
REQ-035 SHALL cover reset mid-frame: reset_n low for 1 cycle with occ=2 -> outputs zero next cycle and FSM IDLE; stale words never appear.
REQ-036 SHALL cover frame counting with FIFO_AXIS_FRAME_CNT_EN defined: 65537 single-beat frames -> frame_cnt=1 after the wrap.

Source files
------------

// File: rtl/eth_fifo_pkg.sv
// rtl/eth_fifo_pkg.sv - shared frame FSM state type, frame counter width and read-credit helper
package eth_fifo_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } frame_state_t;

   localparam int FRAME_CNT_WIDTH = 16;

   // A read may issue only if every word already owned (buffered or in flight) still fits in 2 slots.
   function automatic logic has_room(input logic [1:0] cur_occ, input logic cur_infl,
                                     input logic cur_pop);
      logic [2:0] fill;
      fill = 3'(cur_occ) + 3'(cur_infl) - 3'(cur_pop);
      return fill < 3'd2;
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry output buffer with occupancy count and head-of-queue data
module axis_skid_buf #(
   parameter int DATA_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic                  pop_ok;
   logic                  push_ok;

   assign pop_ok  = pop && (occ != 2'd0);
   assign push_ok = push && ((occ != 2'd2) || pop_ok);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_ok, pop_ok})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_axis_reader.sv
// rtl/fifo_axis_reader.sv - FIFO-to-stream reader with frame tracking and underrun pulse
// Optional frame_cnt output is enabled by defining FIFO_AXIS_FRAME_CNT_EN.
module fifo_axis_reader
   import eth_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
   input  logic                       fifo_empty,
   output logic                       fifo_rd_en,
   output logic [DATA_WIDTH-2:0]      m_axis_tdata,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       frame_active,
   output logic                       underrun
`ifdef FIFO_AXIS_FRAME_CNT_EN
   ,
   output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
`endif
);

   logic                  infl;
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] head;
   logic                  pop;
   frame_state_t          state;

   axis_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (infl),
      .push_data (fifo_rd_data),
      .pop       (pop),
      .occ       (occ),
      .head_data (head)
   );

   // Outputs are forced low while reset is held, even before the first reset edge.
   assign m_axis_tvalid = reset_n && (occ != 2'd0);
   assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-2:0] : '0;
   assign m_axis_tlast  = m_axis_tvalid && head[DATA_WIDTH-1];
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign fifo_rd_en    = reset_n && !fifo_empty && has_room(occ, infl, pop);
   assign underrun      = frame_active && !m_axis_tvalid;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         infl <= 1'b0;
      end else begin
         infl <= fifo_rd_en;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         frame_active <= 1'b0;
      end else if (pop) begin
         if (m_axis_tlast) begin
            state        <= IDLE;
            frame_active <= 1'b0;
         end else begin
            state        <= IN_FRAME;
            frame_active <= 1'b1;
         end
      end
   end

`ifdef FIFO_AXIS_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (pop && m_axis_tlast) begin
         frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb/tb_fifo_axis_reader.sv - directed self-checking bench for fifo_axis_reader
// frame_cnt checks run only when FIFO_AXIS_FRAME_CNT_EN is defined.
module tb_fifo_axis_reader;

   localparam int DW = 9;

   typedef struct packed {
      logic [DW-2:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] word;
      logic [DW-2:0] exp_data;
      logic          exp_last;
      logic          exp_active;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-2:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          frame_active;
   logic          underrun;
`ifdef FIFO_AXIS_FRAME_CNT_EN
   logic [15:0]   frame_cnt;
`endif

   logic [DW-1:0] fmem [256];
   logic [7:0]    wp = '0;
   logic [7:0]    rp = '0;

   beat_t got[$];
   beat_t exp_q[$];
   int    chk_idx = 0;
   int    n_tests = 0;
   int    n_fail  = 0;

   always #5 clk = ~clk;

   fifo_axis_reader #(.DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .frame_active  (frame_active),
      .underrun      (underrun)
`ifdef FIFO_AXIS_FRAME_CNT_EN
      ,
      .frame_cnt     (frame_cnt)
`endif
   );

   // FIFO model with a fixed 1-cycle read latency.
   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= fmem[rp];
         rp           <= rp + 8'd1;
      end
   end

   always @(negedge clk) begin
      if (m_axis_tvalid && m_axis_tready) begin
         got.push_back(beat_t'{data: m_axis_tdata, last: m_axis_tlast});
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time 5000000, required finish earlier");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic edge_drv();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic tick();
      edge_drv();
      settle();
   endtask

   task automatic push_word(input logic [DW-1:0] w, input logic add_exp);
      fmem[wp] = w;
      wp = wp + 8'd1;
      if (add_exp) exp_q.push_back(beat_t'{data: w[DW-2:0], last: w[DW-1]});
   endtask

   task automatic wait_got(input int target, input string name);
      int k = 0;
      while (got.size() < target && k < 200) begin
         tick();
         k++;
      end
      check(name, 32'(got.size() >= target), 1);
   endtask

   task automatic check_beats(input string name);
      check({name, "_count"}, got.size(), exp_q.size());
      for (int i = chk_idx; i < exp_q.size(); i++) begin
         if (i < got.size()) check(name, 32'(got[i]), 32'(exp_q[i]));
      end
      chk_idx = exp_q.size();
   endtask

   initial begin
      vec_t stream_tab[4];
      logic ur_tab[4];
      int   rd_cyc;
      int   v_cyc;
      int   nb;
      int   first;
      int   prev;
      int   und;
      int   base;

      stream_tab[0] = '{9'h0A1, 8'hA1, 1'b0, 1'b1};
      stream_tab[1] = '{9'h0A2, 8'hA2, 1'b0, 1'b1};
      stream_tab[2] = '{9'h0A3, 8'hA3, 1'b0, 1'b1};
      stream_tab[3] = '{9'h1A4, 8'hA4, 1'b1, 1'b0};
      ur_tab[0] = 1'b1;
      ur_tab[1] = 1'b1;
      ur_tab[2] = 1'b1;
      ur_tab[3] = 1'b0;

      // Reset with three words waiting in the FIFO.
      reset_n       = 1'b0;
      m_axis_tready = 1'b1;
      push_word(9'h011, 1'b1);
      push_word(9'h022, 1'b1);
      push_word(9'h133, 1'b1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("rst_tvalid", 32'(m_axis_tvalid), 0);
         check("rst_rd_en", 32'(fifo_rd_en), 0);
      end
      check("rst_tdata", 32'(m_axis_tdata), 0);
      check("rst_tlast", 32'(m_axis_tlast), 0);
      check("rst_active", 32'(frame_active), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_occ", 32'(dut.occ), 0);
`ifdef FIFO_AXIS_FRAME_CNT_EN
      check("rst_frame_cnt", 32'(frame_cnt), 0);
`endif
      edge_drv();
      reset_n = 1'b1;
      settle();
      rd_cyc = -1;
      v_cyc  = -1;
      for (int c = 0; c < 10; c++) begin
         if (fifo_rd_en && rd_cyc < 0) rd_cyc = c;
         if (m_axis_tvalid && v_cyc < 0) v_cyc = c;
         tick();
      end
      check("first_rd_cycle", rd_cyc, 0);
      check("rd_to_tvalid", v_cyc - rd_cyc, 2);
      check_beats("rst_release_beats");
      check("single_frame_idle", 32'(frame_active), 0);

      // Streaming 4-beat frame at full rate.
      edge_drv();
      for (int i = 0; i < 4; i++) push_word(stream_tab[i].word, 1'b1);
      settle();
      nb = 0; first = -1; prev = -1; und = 0;
      for (int c = 0; c < 12; c++) begin
         if (prev >= 0) begin
            check("stream_active", 32'(frame_active), 32'(stream_tab[prev].exp_active));
            prev = -1;
         end
         if (underrun) und++;
         if (m_axis_tvalid && nb < 4) begin
            if (first < 0) first = c;
            check("stream_data", 32'(m_axis_tdata), 32'(stream_tab[nb].exp_data));
            check("stream_last", 32'(m_axis_tlast), 32'(stream_tab[nb].exp_last));
            check("stream_gap", c - first, nb);
            prev = nb;
            nb++;
         end
         tick();
      end
      check("stream_beats", nb, 4);
      check("stream_underrun", und, 0);
      check_beats("stream_sb");

      // Backpressure for 5 cycles after beat 2.
      base = got.size();
      edge_drv();
      push_word(9'h0B1, 1'b1);
      push_word(9'h0B2, 1'b1);
      push_word(9'h0B3, 1'b1);
      push_word(9'h0B4, 1'b1);
      push_word(9'h0B5, 1'b1);
      push_word(9'h1B6, 1'b1);
      settle();
      wait_got(base + 2, "bp_pre");
      for (int c = 0; c < 5; c++) begin
         edge_drv();
         m_axis_tready = 1'b0;
         settle();
         check("bp_tdata", 32'(m_axis_tdata), 32'h0B3);
         check("bp_tvalid", 32'(m_axis_tvalid), 1);
         check("bp_rd_en", 32'(fifo_rd_en), 0);
         if (c > 0) check("bp_occ", 32'(dut.occ), 2);
      end
      edge_drv();
      m_axis_tready = 1'b1;
      settle();
      wait_got(base + 6, "bp_done");
      check_beats("bp_sb");
      tick();
      check("bp_active_end", 32'(frame_active), 0);

      // FIFO starves after beat 2 of a 4-beat frame.
      base = got.size();
      edge_drv();
      push_word(9'h0C1, 1'b1);
      push_word(9'h0C2, 1'b1);
      settle();
      wait_got(base + 2, "ur_pre");
      for (int c = 0; c < 4; c++) begin
         edge_drv();
         if (c == 1) begin
            push_word(9'h0C3, 1'b1);
            push_word(9'h1C4, 1'b1);
         end
         settle();
         check("ur_pulse", 32'(underrun), 32'(ur_tab[c]));
         check("ur_active", 32'(frame_active), 1);
      end
      wait_got(base + 4, "ur_done");
      check_beats("ur_sb");
      tick();
      check("ur_active_end", 32'(frame_active), 0);
      check("ur_idle_pulse", 32'(underrun), 0);

      // One-cycle reset mid-frame with a full buffer.
      base = got.size();
      edge_drv();
      push_word(9'h0D1, 1'b1);
      push_word(9'h0D2, 1'b0);
      push_word(9'h0D3, 1'b0);
      push_word(9'h0D4, 1'b0);
      push_word(9'h0D5, 1'b0);
      push_word(9'h1D6, 1'b0);
      settle();
      wait_got(base + 1, "rm_pre");
      edge_drv();
      m_axis_tready = 1'b0;
      settle();
      tick();
      tick();
      check("rm_occ_full", 32'(dut.occ), 2);
      check("rm_active_pre", 32'(frame_active), 1);
      edge_drv();
      reset_n = 1'b0;
      wp = rp;
      settle();
      check("rm_rd_en_in_rst", 32'(fifo_rd_en), 0);
      check("rm_tvalid_in_rst", 32'(m_axis_tvalid), 0);
      edge_drv();
      reset_n = 1'b1;
      m_axis_tready = 1'b1;
      settle();
      check("rm_tvalid", 32'(m_axis_tvalid), 0);
      check("rm_tdata", 32'(m_axis_tdata), 0);
      check("rm_tlast", 32'(m_axis_tlast), 0);
      check("rm_active", 32'(frame_active), 0);
      check("rm_underrun", 32'(underrun), 0);
      check("rm_occ", 32'(dut.occ), 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rm_no_stale", 32'(m_axis_tvalid), 0);
      end
      edge_drv();
      push_word(9'h1E7, 1'b1);
      settle();
      wait_got(base + 2, "rm_new");
      check_beats("rm_sb");
      tick();
      check("rm_single_beat_idle", 32'(frame_active), 0);

`ifdef FIFO_AXIS_FRAME_CNT_EN
      // 65536 single-beat frames wrap the counter, one more leaves it at 1.
      edge_drv();
      reset_n = 1'b0;
      settle();
      edge_drv();
      reset_n = 1'b1;
      settle();
      check("cnt_reset", 32'(frame_cnt), 0);
      base = got.size();
      nb = 0;
      for (int c = 0; c < 70000 && got.size() < base + 65536; c++) begin
         edge_drv();
         if (nb < 65536 && 8'(wp - rp) < 8'd16) begin
            push_word({1'b1, 8'(nb)}, 1'b0);
            nb++;
         end
         settle();
      end
      check("cnt_frames", got.size() - base, 65536);
      tick();
      check("cnt_wrap", 32'(frame_cnt), 0);
      edge_drv();
      push_word(9'h155, 1'b0);
      settle();
      wait_got(base + 65537, "cnt_last");
      tick();
      check("cnt_after_wrap", 32'(frame_cnt), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
